load_store_unit: RTL and testbench

CPU-side load/store sequencer sitting directly upstream of the Avalon-MM data master interface. Accepts one RV32 load/store request from the pipeline memory stage and stalls the pipeline while the access runs. Drives the interface's level-held `start_access`, `MemRead`/`MemWrite`, word address and write data, then waits for its one-cycle `ready`. Sub-word loads are realised as aligned word reads; sub-word stores as read-modify-write, because the bus carries no byte enables.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_byte_lane.sv | 39 +++
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer: FSM states, operation
// and phase encodings, RV32 funct3 codes, parameter defaults, access legality check.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RELEASE = 2'd2,
      S_DONE    = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      OP_LOAD    = 2'd0,
      OP_STORE_W = 2'd1,
      OP_RMW     = 2'd2
   } lsu_op_e;

   typedef enum logic {
      PH_READ  = 1'b0,
      PH_WRITE = 1'b1
   } lsu_phase_e;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam int unsigned GAP_CYCLES_DEF     = 3;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

   // Unsigned sub-word codes exist only for loads; halves and words must be naturally aligned.
   function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                      input logic [1:0] a);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~a[0];
         F3_W:    ok = (a == 2'b00);
         F3_BU:   ok = is_load;
         F3_HU:   ok = is_load & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends a load result from an aligned word
// and merges SB/SH store data into a previously read word.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [2:0]  funct3_i,
   input  logic [15:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(word_i >> {addr_i, 3'b000});
      half_sel = 16'(word_i >> {addr_i[1], 4'b0000});
      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    load_data_o = word_i;
         F3_BU:   load_data_o = {24'h0, byte_sel};
         F3_HU:   load_data_o = {16'h0, half_sel};
         default: load_data_o = '0;
      endcase
   end

   always_comb begin
      merged_o = word_i;
      case (funct3_i)
         F3_B:    merged_o[{addr_i, 3'b000} +: 8]     = store_data_i[7:0];
         F3_H:    merged_o[{addr_i[1], 4'b0000} +: 16] = store_data_i;
         default: merged_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store sequencer in front of the Avalon-MM data master interface.
// Optional ISSUE timeout is compiled in when LSU_TIMEOUT_EN is defined.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_is_load,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] load_data,
   output logic        access_err,
   output logic        timeout_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   output logic        start_access,
   input  logic        mem_ready,
   input  logic [31:0] mem_read_data
);

   localparam int unsigned CW = $clog2(GAP_CYCLES + 1);

   if (GAP_CYCLES < 3) begin : g_gap_chk
      $error("GAP_CYCLES must be at least 3");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   lsu_state_e  state_q, state_d;
   lsu_op_e     op_q, op_d;
   lsu_phase_e  phase_q, phase_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] word_q, word_d;
   logic [15:0] wdata_q, wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        start_q, start_d, rd_q, rd_d, wr_q, wr_d, err_q, err_d;
   logic [31:0] lane_load, lane_merged;
   logic        is_access;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic          tmo_q, tmo_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
`else
   logic tmo_q;
   assign tmo_q = 1'b0;
`endif

   lsu_byte_lane u_lane (
      .word_i       (word_q),
      .addr_i       (addr_q[1:0]),
      .funct3_i     (f3_q),
      .store_data_i (wdata_q),
      .load_data_o  (lane_load),
      .merged_o     (lane_merged)
   );

   assign is_access = req_is_load | req_is_store;

   always_comb begin
      state_d = state_q;  op_d = op_q;  phase_d = phase_q;
      addr_d  = addr_q;   word_d = word_q;  wdata_d = wdata_q;  f3_d = f3_q;
      cnt_d   = cnt_q;    start_d = start_q;  rd_d = rd_q;  wr_d = wr_q;  err_d = err_q;
`ifdef LSU_TIMEOUT_EN
      tmo_d = tmo_q;  tcnt_d = tcnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && is_access) begin
               addr_d  = req_addr;
               f3_d    = req_funct3;
               wdata_d = req_wdata[15:0];
               err_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
               tmo_d  = 1'b0;
               tcnt_d = '0;
`endif
               if (!access_ok(req_is_load, req_funct3, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  start_d = 1'b1;
                  if (req_is_load) begin
                     op_d = OP_LOAD;     phase_d = PH_READ;   rd_d = 1'b1;
                  end else if (req_funct3 == F3_W) begin
                     op_d = OP_STORE_W;  phase_d = PH_WRITE;  wr_d = 1'b1;
                     word_d = req_wdata;
                  end else begin
                     op_d = OP_RMW;      phase_d = PH_READ;   rd_d = 1'b1;
                  end
               end
            end
         end
         S_ISSUE: begin
            if (mem_ready) begin
               if (phase_q == PH_READ) word_d = mem_read_data;
               start_d = 1'b0;  rd_d = 1'b0;  wr_d = 1'b0;
               cnt_d   = CW'(GAP_CYCLES);
               state_d = S_RELEASE;
`ifdef LSU_TIMEOUT_EN
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               tmo_d   = 1'b1;
               start_d = 1'b0;  rd_d = 1'b0;  wr_d = 1'b0;
               cnt_d   = CW'(GAP_CYCLES);
               state_d = S_RELEASE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
`endif
            end
         end
         S_RELEASE: begin
            if (cnt_q <= CW'(1)) begin
               // A timed-out RMW read must never turn into a write.
               if (op_q == OP_RMW && phase_q == PH_READ && !tmo_q) begin
                  word_d  = lane_merged;
                  phase_d = PH_WRITE;
                  start_d = 1'b1;
                  wr_d    = 1'b1;
                  state_d = S_ISSUE;
`ifdef LSU_TIMEOUT_EN
                  tcnt_d = '0;
`endif
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;   op_q <= OP_LOAD;  phase_q <= PH_READ;
         addr_q  <= '0;       word_q <= '0;     wdata_q <= '0;  f3_q <= '0;
         cnt_q   <= '0;       start_q <= 1'b0;  rd_q <= 1'b0;   wr_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         tmo_q <= 1'b0;  tcnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;  op_q <= op_d;      phase_q <= phase_d;
         addr_q  <= addr_d;   word_q <= word_d;  wdata_q <= wdata_d;  f3_q <= f3_d;
         cnt_q   <= cnt_d;    start_q <= start_d; rd_q <= rd_d;  wr_q <= wr_d;
         err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
         tmo_q <= tmo_d;  tcnt_q <= tcnt_d;
`endif
      end
   end

   // Combinational outputs are gated so everything reads 0 while reset is held.
   assign done = ~reset & ((state_q == S_DONE) |
                           ((state_q == S_IDLE) & req_valid & ~is_access));
   assign stall       = ~reset & req_valid & ~done;
   assign access_err  = (state_q == S_DONE) & err_q;
   assign timeout_err = (state_q == S_DONE) & tmo_q;
   assign load_data   = ((state_q == S_DONE) && (op_q == OP_LOAD) && !err_q && !tmo_q)
                        ? lane_load : '0;
   assign mem_address    = {addr_q[31:2], 2'b00};
   assign mem_write_data = wr_q ? word_q : '0;
   assign mem_read       = rd_q;
   assign mem_write      = wr_q;
   assign start_access   = start_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (GAP_CYCLES=3, TIMEOUT_CYCLES=8).
module tb_load_store_unit;

   logic        clk, reset;
   logic        req_valid, req_is_load, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, done, access_err, timeout_err;
   logic [31:0] load_data, mem_address, mem_write_data, mem_read_data;
   logic        mem_read, mem_write, start_access, mem_ready;

   int unsigned checks = 0;
   int unsigned errors = 0;

   load_store_unit #(.GAP_CYCLES(3), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_is_load(req_is_load), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .done(done), .load_data(load_data),
      .access_err(access_err), .timeout_err(timeout_err),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write), .start_access(start_access),
      .mem_ready(mem_ready), .mem_read_data(mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rdata;
      int unsigned dly;
      logic [31:0] exp_ld;
      logic        exp_aerr;
      int unsigned exp_done, exp_phases, exp_writes;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[15];

   int unsigned r_done_n, r_phases, r_writes;
   logic [31:0] r_ld, r_wdata;
   logic        r_aerr, r_terr, r_bad, r_start_at_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int unsigned dly);
      int unsigned since;
      logic prev_start;
      bit got;
      @(negedge clk);
      req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata; mem_ready = 1'b0;
      prev_start = 1'b0; since = 0; got = 1'b0;
      r_done_n = 0; r_phases = 0; r_writes = 0; r_wdata = '0; r_ld = '0;
      r_aerr = 1'b0; r_terr = 1'b0; r_bad = 1'b0; r_start_at_done = 1'b0;
      for (int n = 1; n <= 200 && !got; n++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (stall !== (req_valid & ~done)) r_bad = 1'b1;
         if (start_access) begin
            if (!prev_start) begin
               r_phases++;
               since = 0;
               if (mem_write) begin r_writes++; r_wdata = mem_write_data; end
            end else since++;
            if (mem_read === mem_write) r_bad = 1'b1;
            if (mem_address !== {addr[31:2], 2'b00}) r_bad = 1'b1;
            if (mem_read && mem_write_data !== 32'h0) r_bad = 1'b1;
            if (since == dly) begin mem_ready = 1'b1; mem_read_data = rdata; end
         end
         prev_start = start_access;
         if (done) begin
            got = 1'b1;
            r_done_n = n; r_ld = load_data; r_aerr = access_err; r_terr = timeout_err;
            r_start_at_done = start_access;
            req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
         end
      end
      mem_ready = 1'b0;
      req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
   endtask

   initial begin
      //            ld    st    f3    addr          wdata         rdata         dly  exp_ld        aerr  done ph wr exp_wdata
      vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 4,   32'hDEADBEEF, 1'b0, 9,   1, 0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF0000, 1,   32'hFFFFFF80, 1'b0, 6,   1, 0, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF0000, 1,   32'h00000080, 1'b0, 6,   1, 0, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0,        32'h80FF0000, 2,   32'hFFFF80FF, 1'b0, 7,   1, 0, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0100, 32'h0,        32'h80FF8001, 0,   32'h00008001, 1'b0, 5,   1, 0, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0101, 32'h0,        32'h12345678, 1,   32'h00000056, 1'b0, 6,   1, 0, 32'h0};
      vecs[6]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0300, 32'hCAFEF00D, 32'h0,        2,   32'h0,        1'b0, 7,   1, 1, 32'hCAFEF00D};
      vecs[7]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h00001234, 32'hAABBCCDD, 1,   32'h0,        1'b0, 11,  2, 1, 32'h1234CCDD};
      vecs[8]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0201, 32'hFFFFFFA5, 32'hAABBCCDD, 0,   32'h0,        1'b0, 9,   2, 1, 32'hAABBA5DD};
      vecs[9]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0200, 32'hFFFF5678, 32'h11223344, 0,   32'h0,        1'b0, 9,   2, 1, 32'h11225678};
      vecs[10] = '{1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,        0,   32'h0,        1'b1, 1,   0, 0, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0,        32'h0,        0,   32'h0,        1'b1, 1,   0, 0, 32'h0};
      vecs[12] = '{1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h0,        32'h0,        0,   32'h0,        1'b1, 1,   0, 0, 32'h0};
      vecs[13] = '{1'b1, 1'b0, 3'd1, 32'h0000_0103, 32'h0,        32'h0,        0,   32'h0,        1'b1, 1,   0, 0, 32'h0};
      vecs[14] = '{1'b1, 1'b1, 3'd2, 32'h0000_0400, 32'h0,        32'h5A5A5A5A, 1,   32'h5A5A5A5A, 1'b0, 6,   1, 0, 32'h0};

      reset = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
      req_funct3 = '0; req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_read_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_start", {31'h0, start_access}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_addr", mem_address, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].dly);
         chk($sformatf("v%0d_done_cycle", i), r_done_n, vecs[i].exp_done);
         chk($sformatf("v%0d_load_data", i), r_ld, vecs[i].exp_ld);
         chk($sformatf("v%0d_access_err", i), {31'h0, r_aerr}, {31'h0, vecs[i].exp_aerr});
         chk($sformatf("v%0d_timeout_err", i), {31'h0, r_terr}, 32'h0);
         chk($sformatf("v%0d_phases", i), r_phases, vecs[i].exp_phases);
         chk($sformatf("v%0d_writes", i), r_writes, vecs[i].exp_writes);
         chk($sformatf("v%0d_bus_protocol", i), {31'h0, r_bad}, 32'h0);
         if (vecs[i].exp_writes != 0)
            chk($sformatf("v%0d_write_data", i), r_wdata, vecs[i].exp_wdata);
      end

      // Request with neither load nor store completes combinationally.
      @(negedge clk);
      req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b0;
      #1;
      chk("noop_done", {31'h0, done}, 32'h1);
      chk("noop_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      chk("noop_no_start", {31'h0, start_access}, 32'h0);
      chk("noop_no_read", {31'h0, mem_read}, 32'h0);
      req_valid = 1'b0;

      // mem_ready while idle must be ignored.
      @(negedge clk);
      mem_ready = 1'b1; mem_read_data = 32'h55AA55AA;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("idle_ready_done", {31'h0, done}, 32'h0);
      chk("idle_ready_start", {31'h0, start_access}, 32'h0);

      // Reset asserted mid-ISSUE.
      @(negedge clk);
      req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'd2; req_addr = 32'h500;
      @(negedge clk);
      chk("pre_rst_start", {31'h0, start_access}, 32'h1);
      reset = 1'b1;
      #1;
      chk("mid_rst_start", {31'h0, start_access}, 32'h0);
      chk("mid_rst_rdwr", {30'h0, mem_read, mem_write}, 32'h0);
      chk("mid_rst_addr", mem_address, 32'h0);
      chk("mid_rst_wdata", mem_write_data, 32'h0);
      chk("mid_rst_done_err", {29'h0, done, access_err, timeout_err}, 32'h0);
      chk("mid_rst_load", load_data, 32'h0);
      @(negedge clk);
      req_valid = 1'b0; req_is_load = 1'b0;
      reset = 1'b0;
      run(1'b1, 1'b0, 3'd2, 32'h504, 32'h0, 32'h0BADF00D, 2);
      chk("post_rst_done_cycle", r_done_n, 32'd7);
      chk("post_rst_load", r_ld, 32'h0BADF00D);

`ifdef LSU_TIMEOUT_EN
      run(1'b1, 1'b0, 3'd2, 32'h600, 32'h0, 32'h0, 1000);
      chk("tmo_done_cycle", r_done_n, 32'd12);
      chk("tmo_err", {31'h0, r_terr}, 32'h1);
      chk("tmo_load", r_ld, 32'h0);
      chk("tmo_start_low", {31'h0, r_start_at_done}, 32'h0);
      run(1'b0, 1'b1, 3'd0, 32'h601, 32'h0, 32'h0, 1000);
      chk("tmo_rmw_done_cycle", r_done_n, 32'd12);
      chk("tmo_rmw_err", {31'h0, r_terr}, 32'h1);
      chk("tmo_rmw_writes", r_writes, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
